// File: rtl/kbd_event_decoder_if.sv
// Byte-receiver and event-consumer signals of kbd_event_decoder.
// The master side drives bytes and ev_ready; the slave side is the decoder.
interface kbd_event_decoder_if;
  logic       ps2_ready;
  logic [7:0] ps2_byte;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [3:0] ev_mods;

  modport master (
    output ps2_ready, ps2_byte, ps2_overflow, ev_ready,
    input  ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_mods
  );

  modport slave (
    input  ps2_ready, ps2_byte, ps2_overflow, ev_ready,
    output ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_mods
  );
endinterface

// File: rtl/kbd_event_decoder.sv
// PS/2 scancode-set-2 decoder: prefix parsing, modifier/caps tracking,
// optional typematic repeat filtering, and a first-word-fall-through event FIFO.
module kbd_event_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPORT_BREAK  = 1,
  parameter int REPEAT_FILTER = 1
) (
  input  logic               clk,
  input  logic               rst,
  kbd_event_decoder_if.slave bus,
  output logic               caps_lock,
  output logic               overflow,
  input  logic               clr_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_PAUSE} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } event_t;

  state_t     state, state_nx;
  logic       ext_q, ext_nx;
  logic [2:0] cnt_q, cnt_nx;
  logic       nextdata_n;
  logic       accept;

  logic       key_valid, key_ext, key_brk, key_pause;
  logic [7:0] key_code;

  // {ralt, lalt, rctrl, lctrl, rshift, lshift}
  logic [5:0] mod_q, mod_nx;
  logic       caps_nx;
  logic       lm_valid, lm_valid_nx, lm_ext, lm_ext_nx;
  logic [7:0] lm_code, lm_code_nx;
  logic       fake, repeat_make, push_req;
  event_t     new_ev, head;

  event_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, push, drop;

  function automatic logic is_noise(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign accept             = bus.ps2_ready & nextdata_n;
  assign bus.ps2_nextdata_n = nextdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ext_q      <= 1'b0;
      cnt_q      <= '0;
      nextdata_n <= 1'b1;
    end else begin
      state      <= state_nx;
      ext_q      <= ext_nx;
      cnt_q      <= cnt_nx;
      nextdata_n <= ~accept;
    end
  end

  always_comb begin
    state_nx  = state;
    ext_nx    = ext_q;
    cnt_nx    = cnt_q;
    key_valid = 1'b0;
    key_code  = bus.ps2_byte;
    key_ext   = 1'b0;
    key_brk   = 1'b0;
    key_pause = 1'b0;
    if (bus.ps2_overflow) begin
      state_nx = S_IDLE;
    end else if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (bus.ps2_byte == 8'hE0) begin
            state_nx = S_EXT;
          end else if (bus.ps2_byte == 8'hF0) begin
            state_nx = S_BRK;
            ext_nx   = 1'b0;
          end else if (bus.ps2_byte == 8'hE1) begin
            state_nx = S_PAUSE;
            cnt_nx   = 3'd7;
          end else if (!is_noise(bus.ps2_byte)) begin
            key_valid = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.ps2_byte == 8'hF0) begin
            state_nx = S_BRK;
            ext_nx   = 1'b1;
          end else if (bus.ps2_byte != 8'hE0) begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            state_nx  = S_IDLE;
          end
        end
        S_BRK: begin
          if (bus.ps2_byte == 8'hE0) begin
            ext_nx = 1'b1;
          end else if (bus.ps2_byte != 8'hF0) begin
            key_valid = 1'b1;
            key_ext   = ext_q;
            key_brk   = 1'b1;
            state_nx  = S_IDLE;
          end
        end
        S_PAUSE: begin
          cnt_nx = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            key_valid = 1'b1;
            key_pause = 1'b1;
            key_code  = 8'h77;
            key_ext   = 1'b1;
            state_nx  = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Pause bypasses repeat detection and never touches last_make.
  always_comb begin
    mod_nx      = mod_q;
    caps_nx     = caps_lock;
    lm_valid_nx = lm_valid;
    lm_ext_nx   = lm_ext;
    lm_code_nx  = lm_code;
    push_req    = 1'b0;
    fake        = key_ext & ((key_code == 8'h12) | (key_code == 8'h59));
    repeat_make = ~key_brk & ~key_pause & lm_valid & (lm_ext == key_ext) & (lm_code == key_code);
    if (key_valid & ~fake) begin
      case ({key_ext, key_code})
        9'h012:  mod_nx[0] = ~key_brk;
        9'h059:  mod_nx[1] = ~key_brk;
        9'h014:  mod_nx[2] = ~key_brk;
        9'h114:  mod_nx[3] = ~key_brk;
        9'h011:  mod_nx[4] = ~key_brk;
        9'h111:  mod_nx[5] = ~key_brk;
        default: ;
      endcase
      if (~key_brk & ~repeat_make & ~key_pause & ~key_ext & (key_code == 8'h58))
        caps_nx = ~caps_lock;
      if (key_brk) begin
        if (lm_valid & (lm_ext == key_ext) & (lm_code == key_code))
          lm_valid_nx = 1'b0;
      end else if (~repeat_make & ~key_pause) begin
        lm_valid_nx = 1'b1;
        lm_ext_nx   = key_ext;
        lm_code_nx  = key_code;
      end
      push_req = (~key_brk | (REPORT_BREAK != 0)) & ~(repeat_make & (REPEAT_FILTER != 0));
    end
  end

  always_comb begin
    new_ev.code = key_code;
    new_ev.ext  = key_ext;
    new_ev.brk  = key_brk;
    new_ev.mods = {caps_nx, mod_nx[5] | mod_nx[4], mod_nx[1] | mod_nx[0], mod_nx[3] | mod_nx[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mod_q     <= '0;
      caps_lock <= 1'b0;
      lm_valid  <= 1'b0;
      lm_ext    <= 1'b0;
      lm_code   <= '0;
    end else begin
      mod_q     <= mod_nx;
      caps_lock <= caps_nx;
      lm_valid  <= lm_valid_nx;
      lm_ext    <= lm_ext_nx;
      lm_code   <= lm_code_nx;
    end
  end

  assign bus.ev_valid = (count != '0);
  assign pop          = bus.ev_valid & bus.ev_ready;
  assign push         = push_req & ((count < DEPTH_C) | pop);
  assign drop         = push_req & ~push;
  assign head         = mem[rd_ptr];

  // Outputs read as zero while empty so the reset values hold without clearing storage.
  assign bus.ev_code  = bus.ev_valid ? head.code : '0;
  assign bus.ev_ext   = bus.ev_valid & head.ext;
  assign bus.ev_break = bus.ev_valid & head.brk;
  assign bus.ev_mods  = bus.ev_valid ? head.mods : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          overflow <= 1'b0;
    else if (drop | bus.ps2_overflow) overflow <= 1'b1;
    else if (clr_overflow)            overflow <= 1'b0;
  end
endmodule

// File: tb/tb_kbd_event_decoder.sv
// Bench for kbd_event_decoder: three parameter variants share one byte stream
// and are compared each cycle against a sequence-level reference model.
module tb_kbd_event_decoder;
  localparam int DEP [3] = '{4, 8, 8};
  localparam bit RB  [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit RF  [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_ready, ps2_overflow, clr_overflow;
  logic [7:0] ps2_byte;
  logic [2:0] rdy, caps_o, ovf_o;
  int         total = 0, bad = 0;
  int         cnt [3];

  kbd_event_decoder_if ia (), ib (), ic ();

  assign ia.ps2_ready = ps2_ready;  assign ia.ps2_byte = ps2_byte;
  assign ia.ps2_overflow = ps2_overflow;  assign ia.ev_ready = rdy[0];
  assign ib.ps2_ready = ps2_ready;  assign ib.ps2_byte = ps2_byte;
  assign ib.ps2_overflow = ps2_overflow;  assign ib.ev_ready = rdy[1];
  assign ic.ps2_ready = ps2_ready;  assign ic.ps2_byte = ps2_byte;
  assign ic.ps2_overflow = ps2_overflow;  assign ic.ev_ready = rdy[2];

  kbd_event_decoder #(.FIFO_DEPTH(4), .REPORT_BREAK(1), .REPEAT_FILTER(1)) u_a (
    .clk(clk), .rst(rst), .bus(ia), .caps_lock(caps_o[0]), .overflow(ovf_o[0]), .clr_overflow(clr_overflow));
  kbd_event_decoder #(.FIFO_DEPTH(8), .REPORT_BREAK(1), .REPEAT_FILTER(0)) u_b (
    .clk(clk), .rst(rst), .bus(ib), .caps_lock(caps_o[1]), .overflow(ovf_o[1]), .clr_overflow(clr_overflow));
  kbd_event_decoder #(.FIFO_DEPTH(8), .REPORT_BREAK(0), .REPEAT_FILTER(1)) u_c (
    .clk(clk), .rst(rst), .bus(ic), .caps_lock(caps_o[2]), .overflow(ovf_o[2]), .clr_overflow(clr_overflow));

  always #5 clk = ~clk;

  // Reference model: prefix bytes are collected until a sequence completes.
  logic [7:0]  pend [$];
  bit          m_nd, m_caps, lm_v, lm_e;
  logic [7:0]  lm_c;
  bit          lsh, rsh, lct, rct, lal, ral;
  logic [13:0] mf [3][8];
  int          mhd [3], mn [3];
  bit          movf [3];

  always @(posedge clk) begin : model
    bit acc, ev, e_ext, e_brk, e_pause, fake, rep, drop;
    bit want [3];
    logic [7:0] e_code;
    logic [3:0] mods;
    if (rst) begin
      pend.delete();
      m_nd = 1; m_caps = 0; lm_v = 0; lm_e = 0; lm_c = 0;
      {lsh, rsh, lct, rct, lal, ral} = '0;
      for (int k = 0; k < 3; k++) begin mhd[k] = 0; mn[k] = 0; movf[k] = 0; end
    end else begin
      acc = ps2_ready && m_nd;
      m_nd = !acc;
      ev = 0; e_code = ps2_byte; e_ext = 0; e_brk = 0; e_pause = 0;
      if (ps2_overflow) pend.delete();
      else if (acc) begin
        if (pend.size() == 0 && (ps2_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
        end else if (pend.size() != 0 && pend[0] == 8'hE1) begin
          pend.push_back(ps2_byte);
          if (pend.size() == 8) begin
            ev = 1; e_code = 8'h77; e_ext = 1; e_pause = 1; pend.delete();
          end
        end else if (ps2_byte == 8'hE0 || ps2_byte == 8'hF0 || (ps2_byte == 8'hE1 && pend.size() == 0)) begin
          pend.push_back(ps2_byte);
        end else begin
          ev = 1;
          foreach (pend[i]) begin
            if (pend[i] == 8'hE0) e_ext = 1;
            if (pend[i] == 8'hF0) e_brk = 1;
          end
          pend.delete();
        end
      end
      fake = e_ext && (e_code == 8'h12 || e_code == 8'h59);
      for (int k = 0; k < 3; k++) want[k] = 0;
      if (ev && !fake) begin
        rep = !e_pause && !e_brk && lm_v && lm_e == e_ext && lm_c == e_code;
        if (!e_ext && e_code == 8'h12) lsh = !e_brk;
        if (!e_ext && e_code == 8'h59) rsh = !e_brk;
        if (!e_ext && e_code == 8'h14) lct = !e_brk;
        if ( e_ext && e_code == 8'h14) rct = !e_brk;
        if (!e_ext && e_code == 8'h11) lal = !e_brk;
        if ( e_ext && e_code == 8'h11) ral = !e_brk;
        if (!e_brk && !rep && !e_pause && !e_ext && e_code == 8'h58) m_caps = !m_caps;
        if (e_brk) begin
          if (lm_v && lm_e == e_ext && lm_c == e_code) lm_v = 0;
        end else if (!rep && !e_pause) begin
          lm_v = 1; lm_e = e_ext; lm_c = e_code;
        end
        for (int k = 0; k < 3; k++) want[k] = !(e_brk && !RB[k]) && !(rep && RF[k]);
      end
      mods = {m_caps, lal | ral, lsh | rsh, lct | rct};
      for (int k = 0; k < 3; k++) begin
        drop = 0;
        if (mn[k] > 0 && rdy[k]) begin mhd[k] = (mhd[k] + 1) % 8; mn[k]--; end
        if (want[k]) begin
          if (mn[k] < DEP[k]) begin
            mf[k][(mhd[k] + mn[k]) % 8] = {e_code, e_ext, e_brk, mods};
            mn[k]++;
          end else drop = 1;
        end
        if (drop || ps2_overflow) movf[k] = 1;
        else if (clr_overflow) movf[k] = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (ia.ev_valid && rdy[0]) cnt[0]++;
    if (ib.ev_valid && rdy[1]) cnt[1]++;
    if (ic.ev_valid && rdy[2]) cnt[2]++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [13:0] h, input logic nd,
                     input logic cp, input logic ov);
    chk($sformatf("m%0d_valid", k), v, mn[k] > 0);
    if (mn[k] > 0) chk($sformatf("m%0d_head", k), h, mf[k][mhd[k]]);
    chk($sformatf("m%0d_nextdata_n", k), nd, m_nd);
    chk($sformatf("m%0d_caps", k), cp, m_caps);
    chk($sformatf("m%0d_overflow", k), ov, movf[k]);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp(0, ia.ev_valid, {ia.ev_code, ia.ev_ext, ia.ev_break, ia.ev_mods}, ia.ps2_nextdata_n, caps_o[0], ovf_o[0]);
    cmp(1, ib.ev_valid, {ib.ev_code, ib.ev_ext, ib.ev_break, ib.ev_mods}, ib.ps2_nextdata_n, caps_o[1], ovf_o[1]);
    cmp(2, ic.ev_valid, {ic.ev_code, ic.ev_ext, ic.ev_break, ic.ev_mods}, ic.ps2_nextdata_n, caps_o[2], ovf_o[2]);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_ready = 1; ps2_byte = b;
    tick();
    chk("nextdata_low", ia.ps2_nextdata_n, 0);
    ps2_ready = 0;
    tick();
    chk("nextdata_high", ia.ps2_nextdata_n, 1);
  endtask

  task automatic head_a(input string n, input logic [13:0] e);
    chk({n, "_valid"}, ia.ev_valid, 1);
    chk(n, {ia.ev_code, ia.ev_ext, ia.ev_break, ia.ev_mods}, e);
  endtask

  task automatic pop_a(input string n, input logic [13:0] e);
    head_a(n, e);
    rdy[0] = 1; tick(); rdy[0] = 0;
  endtask

  task automatic reset_values(input string n);
    chk({n, "_valid"}, ia.ev_valid, 0);
    chk({n, "_fields"}, {ia.ev_code, ia.ev_ext, ia.ev_break, ia.ev_mods}, 0);
    chk({n, "_nextdata_n"}, ia.ps2_nextdata_n, 1);
    chk({n, "_caps"}, caps_o, 0);
    chk({n, "_overflow"}, ovf_o, 0);
  endtask

  function automatic logic [13:0] ev14(input logic [7:0] c, input bit x, input bit b, input logic [3:0] m);
    return {c, x, b, m};
  endfunction

  typedef struct {
    logic [7:0]  b;
    bit          ev;
    logic [13:0] e;
    bit          caps;
  } vec_t;
  vec_t tv [$];

  function automatic void add(input logic [7:0] b, input bit ev, input logic [13:0] e, input bit caps);
    vec_t v;
    v.b = b; v.ev = ev; v.e = e; v.caps = caps;
    tv.push_back(v);
  endfunction

  function automatic void add_n(input logic [7:0] b, input bit caps);
    add(b, 0, '0, caps);
  endfunction

  function automatic logic [7:0] pick(input logic [7:0] last);
    case ($urandom_range(0, 15))
      0: return 8'hE0;  1: return 8'hF0;  2: return 8'h12;  3: return 8'h59;
      4: return 8'h14;  5: return 8'h11;  6: return 8'h58;  7: return 8'h1C;
      8, 9: return last;
      10: return 8'hE1; 11: return 8'hFA;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] last;
    add(8'h1C, 1, ev14(8'h1C, 0, 0, 4'b0000), 0);
    add_n(8'hF0, 0); add(8'h1C, 1, ev14(8'h1C, 0, 1, 4'b0000), 0);
    add_n(8'hE0, 0); add_n(8'h12, 0); add_n(8'hE0, 0); add(8'h7C, 1, ev14(8'h7C, 1, 0, 4'b0000), 0);
    add_n(8'hE0, 0); add_n(8'hF0, 0); add(8'h7C, 1, ev14(8'h7C, 1, 1, 4'b0000), 0);
    add_n(8'hE0, 0); add_n(8'hF0, 0); add_n(8'h12, 0);
    add(8'h12, 1, ev14(8'h12, 0, 0, 4'b0010), 0);
    add(8'h1C, 1, ev14(8'h1C, 0, 0, 4'b0010), 0);
    add_n(8'hF0, 0); add(8'h12, 1, ev14(8'h12, 0, 1, 4'b0000), 0);
    add(8'h58, 1, ev14(8'h58, 0, 0, 4'b1000), 1);
    add_n(8'hF0, 1); add(8'h58, 1, ev14(8'h58, 0, 1, 4'b1000), 1);
    add(8'h1C, 1, ev14(8'h1C, 0, 0, 4'b1000), 1);
    add(8'h58, 1, ev14(8'h58, 0, 0, 4'b0000), 0);
    add_n(8'hF0, 0); add(8'h58, 1, ev14(8'h58, 0, 1, 4'b0000), 0);
    add(8'h58, 1, ev14(8'h58, 0, 0, 4'b1000), 1);
    add_n(8'h58, 1); add_n(8'h58, 1);
    add_n(8'hF0, 1); add(8'h58, 1, ev14(8'h58, 0, 1, 4'b1000), 1);
    add_n(8'hE1, 1); add_n(8'h14, 1); add_n(8'h77, 1); add_n(8'hE1, 1);
    add_n(8'hF0, 1); add_n(8'h14, 1); add_n(8'hF0, 1);
    add(8'h77, 1, ev14(8'h77, 1, 0, 4'b1000), 1);
    add_n(8'hE0, 1); add(8'h14, 1, ev14(8'h14, 1, 0, 4'b1001), 1);
    add(8'h11, 1, ev14(8'h11, 0, 0, 4'b1101), 1);
    add_n(8'hF0, 1); add(8'h11, 1, ev14(8'h11, 0, 1, 4'b1001), 1);
    add_n(8'hE0, 1); add_n(8'hF0, 1); add(8'h14, 1, ev14(8'h14, 1, 1, 4'b1000), 1);
    add_n(8'hFA, 1); add_n(8'hAA, 1);
    add(8'h58, 1, ev14(8'h58, 0, 0, 4'b0000), 0);

    rst = 1; ps2_ready = 0; ps2_byte = 0; ps2_overflow = 0; clr_overflow = 0; rdy = 3'b110;
    tick(); tick();
    rst = 0;
    reset_values("reset");

    foreach (tv[i]) begin
      send(tv[i].b);
      chk($sformatf("tv%0d_valid", i), ia.ev_valid, tv[i].ev);
      if (tv[i].ev) chk($sformatf("tv%0d_event", i), {ia.ev_code, ia.ev_ext, ia.ev_break, ia.ev_mods}, tv[i].e);
      chk($sformatf("tv%0d_caps", i), caps_o[0], tv[i].caps);
      if (ia.ev_valid) begin rdy[0] = 1; tick(); rdy[0] = 0; end
    end

    rdy = 3'b111;
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int i = 0; i < 5; i++) send(8'h1C);
    send(8'hF0); send(8'h1C); tick();
    chk("repeat_filtered_events", cnt[0], 2);
    chk("repeat_unfiltered_events", cnt[1], 6);
    chk("no_break_events", cnt[2], 1);

    rdy = 3'b110;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("full_overflow", ovf_o[0], 1);
    head_a("full_head", ev14(8'h15, 0, 0, 4'b0000));
    clr_overflow = 1; tick(); clr_overflow = 0;
    chk("clr_overflow", ovf_o[0], 0);
    ps2_ready = 1; ps2_byte = 8'h35; rdy[0] = 1; tick();
    ps2_ready = 0; rdy[0] = 0; tick();
    chk("push_pop_full_no_drop", ovf_o[0], 0);
    pop_a("after_pp_0", ev14(8'h1D, 0, 0, 4'b0000));
    pop_a("after_pp_1", ev14(8'h24, 0, 0, 4'b0000));
    send(8'hF0);
    ps2_overflow = 1; tick(); ps2_overflow = 0;
    chk("ps2_overflow_sets", ovf_o[0], 1);
    head_a("ps2_overflow_kept", ev14(8'h2D, 0, 0, 4'b0000));
    send(8'h1C);
    pop_a("drain_0", ev14(8'h2D, 0, 0, 4'b0000));
    pop_a("drain_1", ev14(8'h35, 0, 0, 4'b0000));
    pop_a("resync_make", ev14(8'h1C, 0, 0, 4'b0000));
    chk("drained", ia.ev_valid, 0);
    clr_overflow = 1; tick(); clr_overflow = 0;

    send(8'hE0); send(8'hF0);
    rst = 1; tick(); rst = 0;
    reset_values("mid_reset");
    send(8'h1C);
    pop_a("after_reset_make", ev14(8'h1C, 0, 0, 4'b0000));

    last = 8'h1C;
    for (int i = 0; i < 3000; i++) begin
      ps2_ready = ($urandom_range(0, 1) == 1);
      ps2_byte = pick(last);
      last = ps2_byte;
      ps2_overflow = !ps2_ready && ($urandom_range(0, 199) == 0);
      clr_overflow = ($urandom_range(0, 29) == 0);
      rdy = 3'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kbd_event_decoder.md
# kbd_event_decoder

Parametrised PS/2 scancode-set-2 decoder that sits between the `ps2_keyboard` byte receiver and any consumer: ASCII mapper, terminal, or CPU MMIO port. It consumes raw bytes with the receiver's `ready`/`nextdata_n` handshake. It parses E0/F0/E1 prefix sequences, tracks left/right modifiers and Caps Lock, and optionally filters typematic repeats. Complete key events are pushed into an internal FIFO read by the consumer with a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, ≥2.
- `REPORT_BREAK`, 1: 1 = break (release) events are queued; 0 = only make events are queued.
- `REPEAT_FILTER`, 1: 1 = typematic repeat makes are suppressed.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_ready`  in  1  receiver has a byte available.
- `ps2_byte`  in  8  receiver data byte.
- `ps2_overflow`  in  1  receiver overflow flag.
- `ps2_nextdata_n`  out  1  active-low one-cycle pop strobe to the receiver.
- `ev_valid`  out  1  FIFO head is valid.
- `ev_ready`  in  1  consumer accepts the head.
- `ev_code`  out  8  scancode without prefixes.
- `ev_ext`  out  1  key was E0- or E1-prefixed.
- `ev_break`  out  1  1 = release, 0 = press.
- `ev_mods`  out  4  {caps, alt, shift, ctrl}, sampled after this event's own update.
- `caps_lock`  out  1  live Caps Lock state, for the LED.
- `overflow`  out  1  sticky: an event was dropped or `ps2_overflow` was seen.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- **Byte acceptance:** a byte is accepted in any cycle with `ps2_ready=1` and `ps2_nextdata_n=1`. `ps2_nextdata_n` is registered and goes low for exactly the next cycle. This gives at most one byte per 2 cycles.
- **Parser states:**
  - IDLE:
    - E0 → EXT.
    - F0 → BRK with ext=0.
    - E1 → PAUSE with cnt=7.
    - 00, AA, EE, FA, FC, FD, FE, FF are dropped and the parser stays in IDLE.
    - Any other byte → make event with ext=0.
  - EXT:
    - F0 → BRK with ext=1.
    - E0 → stay in EXT.
    - Any other byte → make event with ext=1, then IDLE.
  - BRK:
    - F0 or E0 → stay in BRK; an E0 here sets ext=1.
    - Any other byte → break event, then IDLE.
  - PAUSE: each byte decrements cnt. The byte that takes cnt to 0 emits make {code=77, ext=1} and returns to IDLE. The repeat filter is not applied.
- **Fake shifts dropped:** ext codes 12 and 59 (make or break) produce no event and no modifier change.
- **Modifier bits:** six internal bits.
  - lshift = 12, rshift = 59.
  - lctrl = 14, rctrl = E0 14.
  - lalt = 11, ralt = E0 11.
  - A make sets the bit and a break clears it.
  - `ev_mods` shift/ctrl/alt are the OR of the left and right bits.
- **Caps Lock:** caps toggles on a non-repeat make of 58 and is unaffected by its break.
- **Repeat filter:** `last_make` = {valid, ext, code}.
  - A make equal to a valid `last_make` is a repeat. It is not queued when `REPEAT_FILTER=1` and does not toggle caps.
  - A break of the `last_make` key clears valid.
  - Any non-repeat make loads `last_make`.
- **Event generation:** all keys produce events, modifiers included. Breaks are queued only if `REPORT_BREAK=1`. Modifier and caps state always update, even when the event is not queued.
- **FIFO:** first-word-fall-through; the head is presented on `ev_*`. A pop happens on `ev_valid & ev_ready`.
  - Push is allowed if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
- **`ps2_overflow=1`:** sets `overflow`, forces the parser to IDLE, and does not flush the FIFO.
- **Overflow flag:** `clr_overflow` clears it. A set condition in the same cycle as `clr_overflow` wins.

## Timing
- **Reset values:** `ps2_nextdata_n=1`, `ev_valid=0`, `ev_code=0`, `ev_ext=0`, `ev_break=0`, `ev_mods=0`, `caps_lock=0`, `overflow=0`. Reset also sets parser IDLE, all modifier bits 0, `last_make` invalid, and FIFO empty.
- **Reset mid-sequence:** a partial prefix sequence is discarded.
- **Latency:** the final byte of a sequence is accepted in cycle N. The event is written at the end of N, and `ev_valid=1` from N+1 if the FIFO was empty. `caps_lock` and the modifier state are also updated at the end of N.
- **Output handshake:** `ev_*` are stable while `ev_valid=1` and `ev_ready=0`. A pop in cycle M presents the next entry, or `ev_valid=0`, in M+1.
- **Count wrap:** read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- **No backpressure to the receiver:** the block never stalls it; a full FIFO drops events rather than blocking bytes.

## Test plan
- **Plain make/break:** bytes 1C, F0 1C with `ev_ready=1` → events {1C, ext0, brk0, mods0} then {1C, ext0, brk1}. `ps2_nextdata_n` low exactly 1 cycle after each accept.
- **Extended keys and fake shift:** E0 12 E0 7C, E0 F0 7C, E0 F0 12 → one make and one break of {7C, ext1}. No shift change and no event for 12.
- **Modifiers and caps:**
  - 12 then 1C → second event mods=0010. F0 12 clears shift.
  - 58, F0 58 → `caps_lock=1` and the next event has mods=1000.
  - Another 58 → `caps_lock=0`.
- **Repeat filter:**
  - With `REPEAT_FILTER=1`: 1C ×5 then F0 1C → exactly 2 events. 58 ×3 toggles caps once.
  - With `REPEAT_FILTER=0`: the same 1C/F0 1C stimulus → 6 events.
- **Pause and overflow:**
  - E1 14 77 E1 F0 14 F0 77 → single event {77, ext1, brk0}.
  - FIFO_DEPTH=4 with `ev_ready=0` and 5 makes → 4 queued, `overflow=1`.
  - Push+pop in the same cycle while full → no drop.
  - `clr_overflow` → `overflow=0`.
- **Reset and resync:**
  - `rst` after E0 F0, then byte 1C → make {1C, ext0}.
  - `ps2_overflow` pulse during BRK → parser IDLE, `overflow=1`, FIFO contents kept.
